fft_input_buffer: RTL and testbench

- Ping-pong sample buffer upstream of the radix-4 butterfly (`butterfly_4`) in the audio FFT path.
- Accepts one signed real audio sample per valid cycle and packs it as a complex word {real, imag=0}.
- Writes each sample at its base-4 digit-reversed address.
- Streams each completed frame as N/4 quads (a, b, c, d) under a valid/ready handshake, ready for first-stage butterflies.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_input_buffer_if.sv | 28 ++
 rtl/pingpong_bank.sv | 30 +++
 rtl/fft_input_buffer.sv | 152 +++++++++++++++
 tb/tb_fft_input_buffer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, complex word layout and
// base-4 digit reversal used across the FFT datapath.
package fft_pkg;

    localparam int FFT_WIDTH = 32;
    localparam int FFT_N     = 16;
    localparam int LOG4N     = $clog2(FFT_N) / 2;

    typedef struct packed {
        logic signed [FFT_WIDTH/2-1:0] re;
        logic signed [FFT_WIDTH/2-1:0] im;
    } cplx_t;

    // Reverses the lowest ndig base-4 digits of idx.
    function automatic int unsigned rev4(input int unsigned idx,
                                         input int unsigned ndig);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < ndig) r = (r << 2) | ((idx >> (2 * i)) & 32'd3);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// Sample-in / quad-out bundle of the FFT input buffer.
// slave is the buffer side, master the producer/consumer side.
interface fft_input_buffer_if
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
);
    logic signed [WIDTH/2-1:0] sample_in;
    logic                      sample_valid;
    logic                      overflow;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [WIDTH-1:0]          c;
    logic [WIDTH-1:0]          d;
    logic                      out_valid;
    logic                      out_ready;
    logic                      frame_start;

    modport slave (
        input  sample_in, sample_valid, out_ready,
        output a, b, c, d, out_valid, frame_start, overflow
    );

    modport master (
        output sample_in, sample_valid, out_ready,
        input  a, b, c, d, out_valid, frame_start, overflow
    );
endinterface

// File: rtl/pingpong_bank.sv
// Two-bank flop array: one word write port, one 4-word quad read port.
// Bank contents carry no reset.
module pingpong_bank #(
    parameter  int WIDTH = 32,
    parameter  int N     = 16,
    localparam int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rbank,
    input  logic [AW-1:0]    rbase,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3
);
    logic [WIDTH-1:0] mem [2][N];

    always_ff @(posedge clk) begin
        if (we) mem[wbank][waddr] <= wdata;
    end

    assign q0 = mem[rbank][rbase];
    assign q1 = mem[rbank][rbase | AW'(1)];
    assign q2 = mem[rbank][rbase | AW'(2)];
    assign q3 = mem[rbank][rbase | AW'(3)];
endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong input buffer: digit-reversed frame writes, registered
// quad reads for the first radix-4 butterfly stage.
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int N     = FFT_N
) (
    input logic                clk,
    input logic                rst_n,
    fft_input_buffer_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam int GW = (AW > 2) ? AW - 2 : 1;
    localparam int NG = N / 4;
    localparam int L4 = AW / 2;

    typedef enum logic {IDLE, STREAM} rstate_t;

    rstate_t          state_q, state_d;
    logic             wb, rb, rb_d;
    logic [1:0]       full, full_d;
    logic [AW-1:0]    wc;
    logic [GW-1:0]    g, g_d, rd_group;
    logic             rd_bank, load, clr, hs;
    logic             vld_q, vld_d, fs_q, fs_d, ovf_q;
    logic [WIDTH-1:0] qa, qb, qc, qd;
    logic [WIDTH-1:0] q0, q1, q2, q3;
    logic [AW-1:0]    waddr, rd_base;
    logic             accept, wlast;

    assign accept  = bus.sample_valid && !full[wb];
    assign wlast   = (wc == AW'(N - 1));
    assign waddr   = AW'(rev4(32'(wc), L4));
    assign rd_base = AW'(rd_group) << 2;

    pingpong_bank #(.WIDTH(WIDTH), .N(N)) u_bank (
        .clk   (clk),
        .we    (accept),
        .wbank (wb),
        .waddr (waddr),
        .wdata ({bus.sample_in, {(WIDTH/2){1'b0}}}),
        .rbank (rd_bank),
        .rbase (rd_base),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        clr      = 1'b0;
        rd_bank  = rb;
        rd_group = g;
        g_d      = g;
        rb_d     = rb;
        vld_d    = vld_q;
        fs_d     = fs_q;
        hs       = vld_q && bus.out_ready;
        unique case (state_q)
            IDLE: begin
                if (full[rb]) state_d = STREAM;
            end
            STREAM: begin
                if (!vld_q) begin
                    load  = 1'b1;
                    vld_d = 1'b1;
                    fs_d  = (g == '0);
                end else if (hs) begin
                    if (g == GW'(NG - 1)) begin
                        clr  = 1'b1;
                        rb_d = ~rb;
                        g_d  = '0;
                        // Other bank already full: chain into it with no bubble.
                        if (full[~rb]) begin
                            load     = 1'b1;
                            rd_bank  = ~rb;
                            rd_group = '0;
                            fs_d     = 1'b1;
                        end else begin
                            vld_d   = 1'b0;
                            fs_d    = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        g_d      = g + 1'b1;
                        load     = 1'b1;
                        rd_group = g + 1'b1;
                        fs_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full_d = full;
        if (clr) full_d[rb] = 1'b0;
        if (accept && wlast) full_d[wb] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb      <= 1'b0;
            rb      <= 1'b0;
            full    <= '0;
            wc      <= '0;
            g       <= '0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            qa      <= '0;
            qb      <= '0;
            qc      <= '0;
            qd      <= '0;
        end else begin
            state_q <= state_d;
            rb      <= rb_d;
            g       <= g_d;
            full    <= full_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            ovf_q   <= bus.sample_valid && full[wb];
            if (accept) begin
                if (wlast) begin
                    wc <= '0;
                    wb <= ~wb;
                end else begin
                    wc <= wc + 1'b1;
                end
            end
            if (load) begin
                qa <= q0;
                qb <= q1;
                qc <= q2;
                qd <= q3;
            end
        end
    end

    assign bus.a           = qa;
    assign bus.b           = qb;
    assign bus.c           = qc;
    assign bus.d           = qd;
    assign bus.out_valid   = vld_q;
    assign bus.frame_start = fs_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer: expected quads are queued
// as frames are fed and checked whenever a quad is presented.
module tb_fft_input_buffer;
    import fft_pkg::*;

    localparam int W = 32;
    localparam int N = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic         fs;
    } quad_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_input_buffer_if #(.WIDTH(W)) bus ();

    fft_input_buffer #(.WIDTH(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    quad_t sb[$];
    int    fbuf[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    run = 0;
    int    max_run = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] cw(input int s);
        cplx_t v;
        v.re = 16'(s);
        v.im = '0;
        return v;
    endfunction

    // Quad g of a digit-reversed 16-point frame is samples g, g+4, g+8, g+12.
    task automatic push_frame();
        quad_t q;
        for (int g = 0; g < N / 4; g++) begin
            q.a  = cw(fbuf[g]);
            q.b  = cw(fbuf[g + 4]);
            q.c  = cw(fbuf[g + 8]);
            q.d  = cw(fbuf[g + 12]);
            q.fs = (g == 0);
            sb.push_back(q);
        end
        fbuf.delete();
    endtask

    task automatic send(input int s, input bit drop);
        bus.sample_in    = 16'(s);
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        chk("overflow", W'(bus.overflow), W'(drop));
        if (!drop) begin
            fbuf.push_back(s);
            if (fbuf.size() == N) push_frame();
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", W'(bus.out_valid), W'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", W'(sb.size()), W'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_quad", W'(1), W'(0));
            end else begin
                chk("quad_a", bus.a, sb[0].a);
                chk("quad_b", bus.b, sb[0].b);
                chk("quad_c", bus.c, sb[0].c);
                chk("quad_d", bus.d, sb[0].d);
                chk("frame_start", W'(bus.frame_start), W'(sb[0].fs));
                if (bus.out_ready) void'(sb.pop_front());
            end
            if (bus.out_ready) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end else begin
            run = 0;
            chk("fs_idle", W'(bus.frame_start), W'(0));
        end
    end

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b0;
        #12;
        chk("rst_valid", W'(bus.out_valid), W'(0));
        chk("rst_a", bus.a, W'(0));
        chk("rst_ovf", W'(bus.overflow), W'(0));
        chk("rst_fs", W'(bus.frame_start), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordering and latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(i, 1'b0);
        @(posedge clk); #1;
        chk("lat_t1", W'(bus.out_valid), W'(0));
        @(posedge clk); #1;
        chk("lat_t2", W'(bus.out_valid), W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("lat_hold", W'(bus.out_valid), W'(1));
        @(posedge clk); #1;
        chk("lat_fall", W'(bus.out_valid), W'(0));

        // Overflow, then back-to-back drain of both banks
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(100 + i, 1'b0);
        send(999, 1'b1);
        @(posedge clk); #1;
        chk("ovf_pulse", W'(bus.overflow), W'(0));
        bus.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_run", W'(max_run), W'(8));
        for (int i = 0; i < N; i++) send(300 + i, 1'b0);
        wait_drain();

        // Backpressure on quad 2
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(400 + 3 * i, 1'b0);
        wait_valid();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_valid", W'(bus.out_valid), W'(1));
        chk("bp_left", W'(sb.size()), W'(2));
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset while quad 1 is presented
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(600 + i, 1'b0);
        wait_valid();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", W'(bus.out_valid), W'(0));
        chk("mrst_a", bus.a, W'(0));
        chk("mrst_b", bus.b, W'(0));
        chk("mrst_c", bus.c, W'(0));
        chk("mrst_d", bus.d, W'(0));
        chk("mrst_fs", W'(bus.frame_start), W'(0));
        chk("mrst_ovf", W'(bus.overflow), W'(0));
        sb.delete();
        fbuf.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(i, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
